// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Unsigned word-index range check against the program memory depth.
  function automatic logic pc_in_range(input logic [31:0] pc, input logic [31:0] depth);
    return pc < depth;
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module fetch_sequencer_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: drives program-memory pc, registers words toward decode,
// and handles start/halt, branch redirect, decode stall and pc range faults.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      start_pc_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_out_o,
  output logic             instr_valid_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic        cnt_clr, cnt_inc;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    halted_d = halted_q;
    fault_d  = fault_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) begin
          pc_d     = start_pc_i;
          cnt_clr  = 1'b1;
          halted_d = 1'b0;
          fault_d  = 1'b0;
          state_d  = S_FETCH;
          if (!pc_in_range(start_pc_i, DEPTH)) begin
            halted_d = 1'b1;
            fault_d  = 1'b1;
            state_d  = S_HALTED;
          end
        end
      end
      S_FETCH: begin
        // Redirect squashes the word at the current pc even under stall.
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          if (!pc_in_range(redirect_pc_i, DEPTH)) begin
            halted_d = 1'b1;
            fault_d  = 1'b1;
            state_d  = S_HALTED;
          end
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (mem_rdata_i == HALT_WORD) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          instr_d = mem_rdata_i;
          valid_d = 1'b1;
          cnt_inc = 1'b1;
          pc_d    = pc_inc;
          // Running off the end still issues the last word this cycle.
          if (pc_inc == DEPTH) begin
            halted_d = 1'b1;
            fault_d  = 1'b1;
            state_d  = S_HALTED;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  fetch_sequencer_sat_counter #(.CNT_W(CNT_W)) u_retired (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (retired_o)
  );

  assign pc_o          = pc_q;
  assign instr_out_o   = instr_q;
  assign instr_valid_o = valid_q;
  assign busy_o        = (state_q == S_FETCH);
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed spec scenarios plus randomized traffic, checked every cycle
// against a behavioural fetch model driven by a bench-side program memory.
module tb_fetch_sequencer;

  localparam int DEPTH = 32;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, stall, redirect;
  logic [31:0]   start_pc, redirect_pc, mem_rdata, pc, instr_out;
  logic          instr_valid, busy, halted, fault;
  logic [CW-1:0] retired;

  logic [31:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model state
  bit          m_run, m_halted, m_fault, m_valid;
  logic [31:0] m_pc, m_instr;
  int          m_ret;

  always #5 clk = ~clk;

  assign mem_rdata = (pc < 32'(DEPTH)) ? mem[pc[4:0]] : 32'h0;

  fetch_sequencer #(.MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .start_pc_i    (start_pc),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_rdata_i   (mem_rdata),
    .pc_o          (pc),
    .instr_out_o   (instr_out),
    .instr_valid_o (instr_valid),
    .busy_o        (busy),
    .halted_o      (halted),
    .fault_o       (fault),
    .retired_o     (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the specified behaviour, applied to the inputs held at the edge.
  task automatic model_step();
    m_valid = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_halted = 0; m_fault = 0; m_pc = 0; m_instr = 0; m_ret = 0;
    end else if (!m_run) begin
      if (start) begin
        m_ret = 0; m_halted = 0; m_fault = 0; m_pc = start_pc;
        if (start_pc >= DEPTH) begin m_halted = 1; m_fault = 1; end
        else m_run = 1;
      end
    end else if (redirect) begin
      m_pc = redirect_pc;
      if (redirect_pc >= DEPTH) begin m_halted = 1; m_fault = 1; m_run = 0; end
    end else if (!stall) begin
      if (mem[m_pc[4:0]] == 32'h0) begin
        m_halted = 1; m_run = 0;
      end else begin
        m_instr = mem[m_pc[4:0]];
        m_valid = 1;
        if (m_ret < (1 << CW) - 1) m_ret++;
        m_pc++;
        if (m_pc == DEPTH) begin m_halted = 1; m_fault = 1; m_run = 0; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pc", pc, m_pc);
    chk("instr_out", instr_out, m_instr);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_run));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("retired", 32'(retired), 32'(m_ret));
    if (instr_valid) pulses++;
  endtask

  task automatic do_start(input logic [31:0] spc);
    start = 1'b1; start_pc = spc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_halt();
    for (int i = 0; i < 60 && !halted; i++) tick();
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic run_to_pc(input logic [31:0] target);
    for (int i = 0; i < 60 && pc != target; i++) tick();
    chk("pc_reached", pc, target);
  endtask

  task automatic load_image();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h2008_0000 + 32'(i);
    mem[7]  = 32'h0;
    mem[14] = 32'h2008_0004;
    mem[19] = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    start_pc = '0; redirect_pc = '0;
    load_image();

    tick(); tick();
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Test-1 program from word 0
    pulses = 0;
    do_start(32'd0);
    run_to_halt();
    chk("t1_pulses", 32'(pulses), 32'd7);
    chk("t1_pc", pc, 32'd7);
    chk("t1_retired", 32'(retired), 32'd7);
    chk("t1_fault", 32'(fault), 32'd0);

    // Test-2 program from word 8
    pulses = 0;
    do_start(32'd8);
    run_to_halt();
    chk("t2_pc", pc, 32'd19);
    chk("t2_retired", 32'(retired), 32'd11);
    chk("t2_pulses", 32'(pulses), 32'd11);

    // Redirect at pc=10 to word 14
    do_start(32'd8);
    run_to_pc(32'd10);
    redirect = 1'b1; redirect_pc = 32'd14;
    tick();
    redirect = 1'b0;
    chk("redir_squash", 32'(instr_valid), 32'd0);
    chk("redir_pc", pc, 32'd14);
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    chk("redir_first", instr_out, 32'h2008_0004);
    run_to_halt();
    chk("redir_retired", 32'(retired), 32'd7);

    // Stall three cycles at pc=2
    do_start(32'd0);
    run_to_pc(32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'd2);
      chk("stall_valid", 32'(instr_valid), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("stall_issue_valid", 32'(instr_valid), 32'd1);
    chk("stall_issue_word", instr_out, 32'h2008_0002);
    run_to_halt();

    // Run off the end of memory from word 30
    pulses = 0;
    do_start(32'd30);
    run_to_halt();
    chk("end_pulses", 32'(pulses), 32'd2);
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_last", instr_out, 32'h2008_001F);

    // Out-of-range start from IDLE
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    do_start(32'd40);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_retired", 32'(retired), 32'd0);
    chk("oor_busy", 32'(busy), 32'd0);

    // Reset mid-run at pc=5, then restart
    do_start(32'd0);
    run_to_pc(32'd5);
    rst_n = 1'b0;
    tick();
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    tick();
    do_start(32'd0);
    run_to_halt();
    chk("restart_retired", 32'(retired), 32'd7);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (n % 80 == 0)
        for (int i = 0; i < DEPTH; i++)
          mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
      rst_n       = ($urandom_range(0, 60) != 0);
      start       = ($urandom_range(0, 9) == 0);
      start_pc    = 32'($urandom_range(0, 34));
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 33));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
